fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if_id_reg.sv | 47 ++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select
// encoding, fetch state machine states and instruction constants.
package fetch_unit_pkg;

    // Next-PC select; the reserved code behaves as sequential fetch.
    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JALR   = 2'd2,
        PC_SRC_RSVD   = 2'd3
    } pc_src_e;

    // Fetch state machine states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- inserted into decode whenever IF/ID is flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bytes per instruction word; the sequential PC increment.
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; with neither asserted
// every output holds its value.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_in,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic                     valid_d
);

    localparam logic [DATA_WIDTH-1:0] NOP_D = DATA_WIDTH'(NOP_INSTR);

    // Decode-stage register: reset/flush to a NOP bubble, load on a fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_d       <= '0;
            pc_plus4_d <= '0;
            instr_d    <= NOP_D;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d    <= NOP_D;
            valid_d    <= 1'b0;
        end else if (load) begin
            pc_d       <= pc_in;
            pc_plus4_d <= pc_plus4_in;
            instr_d    <= instr_in;
            valid_d    <= 1'b1;
        end else begin
            pc_d       <= pc_d;
            pc_plus4_d <= pc_plus4_d;
            instr_d    <= instr_d;
            valid_d    <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and the
// BOOT/RUN/HALT control machine, feeding the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = ADDRESS_WIDTH'(32'h0000_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [1:0]               pc_src,
    input  logic [ADDRESS_WIDTH-1:0] target,
    input  logic                     halt_req,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    output logic [ADDRESS_WIDTH-1:0] instr_addr,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic                     valid_d,
    output logic                     misalign,
    output logic                     halted
);

    fetch_state_e             state_r;
    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic                     misalign_r;
    logic                     halted_r;

    logic                     redirect_s;
    logic                     jalr_s;
    logic [ADDRESS_WIDTH-1:0] redirect_pc_s;
    logic                     misaligned_s;
    logic                     halt_s;
    logic                     load_s;
    logic                     flush_s;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_s;

    // Next-PC candidates and IF/ID control, decoded from the current state.
    always_comb begin
        jalr_s     = (pc_src == PC_SRC_JALR);
        pc_plus4_s = pc_r + ADDRESS_WIDTH'(INSTR_BYTES);
        if (state_r == ST_RUN) begin
            redirect_s = jalr_s || (pc_src == PC_SRC_BRANCH);
        end else begin
            redirect_s = 1'b0;
        end
        if (jalr_s) begin
            redirect_pc_s = {target[ADDRESS_WIDTH-1:1], 1'b0};
        end else begin
            redirect_pc_s = target;
        end
        misaligned_s = redirect_s && (redirect_pc_s[1:0] != 2'b00);
        halt_s       = (state_r == ST_RUN) && !redirect_s && halt_req;
        load_s       = (state_r == ST_RUN) && !redirect_s && !halt_req && !stall;
        flush_s      = redirect_s || halt_s;
    end

    // Control machine: owns the PC and the sticky misalign/halted flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_s) begin
                        if (misaligned_s) begin
                            misalign_r <= 1'b1;
                            halted_r   <= 1'b1;
                            state_r    <= ST_HALT;
                        end else begin
                            pc_r <= redirect_pc_s;
                        end
                    end else if (halt_req) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else begin
                        pc_r <= pc_plus4_s;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Unreachable encoding: stop fetching rather than guess.
                    halted_r <= 1'b1;
                    state_r  <= ST_HALT;
                end
            endcase
        end
    end

    assign instr_addr = pc_r;
    assign misalign   = misalign_r;
    assign halted     = halted_r;

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .flush       (flush_s),
        .pc_in       (pc_r),
        .pc_plus4_in (pc_plus4_s),
        .instr_in    (instr_in),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .instr_d     (instr_d),
        .valid_d     (valid_d)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, stall, branch-under-stall, JALR
// masking, halt, async reset, misaligned JALR, and PC wrap (second instance).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] target;
    logic        halt_req;
    logic [31:0] instr_in;
    logic [31:0] instr_addr, pc_d, pc_plus4_d, instr_d;
    logic        valid_d, misalign, halted;

    logic [31:0] instr_in_w;
    logic [31:0] instr_addr_w, pc_d_w, pc_plus4_d_w, instr_d_w;
    logic        valid_d_w, misalign_w, halted_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word = address xor a tag.
    assign instr_in   = instr_addr ^ 32'hCAFE_0000;
    assign instr_in_w = instr_addr_w ^ 32'hCAFE_0000;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .target(target),
        .halt_req(halt_req), .instr_in(instr_in), .instr_addr(instr_addr),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .instr_d(instr_d),
        .valid_d(valid_d), .misalign(misalign), .halted(halted)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .pc_src(2'd0), .target(32'h0000_0000),
        .halt_req(1'b0), .instr_in(instr_in_w), .instr_addr(instr_addr_w),
        .pc_d(pc_d_w), .pc_plus4_d(pc_plus4_d_w), .instr_d(instr_d_w),
        .valid_d(valid_d_w), .misalign(misalign_w), .halted(halted_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},     instr_addr, 32'h0000_0000);
        check({tag, "_pc_d"},     pc_d,       32'h0000_0000);
        check({tag, "_pc4_d"},    pc_plus4_d, 32'h0000_0000);
        check({tag, "_instr_d"},  instr_d,    NOP);
        check({tag, "_valid"},    {31'd0, valid_d},  32'd0);
        check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        check({tag, "_halted"},   {31'd0, halted},   32'd0);
        check({tag, "_wrap_addr"}, instr_addr_w, 32'hFFFF_FFF8);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 2'd0; target = 32'h0; halt_req = 1'b0;
        step();
        step();
        check_reset_state("por");

        // Release mid-cycle; next edge is the BOOT cycle.
        rst = 1'b0;
        step();
        check("boot_addr",  instr_addr, 32'h0000_0000);
        check("boot_valid", {31'd0, valid_d}, 32'd0);
        check("wrap_boot",  instr_addr_w, 32'hFFFF_FFF8);
        step();
        check("seq1_addr",  instr_addr, 32'h0000_0004);
        check("seq1_valid", {31'd0, valid_d}, 32'd1);
        check("seq1_pc_d",  pc_d, 32'h0000_0000);
        check("seq1_pc4",   pc_plus4_d, 32'h0000_0004);
        check("seq1_instr", instr_d, 32'hCAFE_0000);
        check("wrap_fffc",  instr_addr_w, 32'hFFFF_FFFC);
        step();
        check("seq2_addr",  instr_addr, 32'h0000_0008);
        check("seq2_pc_d",  pc_d, 32'h0000_0004);
        check("seq2_instr", instr_d, 32'hCAFE_0004);
        check("wrap_zero",  instr_addr_w, 32'h0000_0000);
        check("wrap_pc_d",  pc_d_w, 32'hFFFF_FFFC);
        check("wrap_pc4",   pc_plus4_d_w, 32'h0000_0000);
        check("wrap_nomis", {31'd0, misalign_w}, 32'd0);

        // Stall three cycles at PC=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  instr_addr, 32'h0000_0008);
            check("stall_pc_d",  pc_d, 32'h0000_0004);
            check("stall_instr", instr_d, 32'hCAFE_0004);
            check("stall_valid", {31'd0, valid_d}, 32'd1);
        end

        // Branch overrides a concurrent stall.
        pc_src = 2'd1; target = 32'h0000_0040;
        step();
        check("br_addr",  instr_addr, 32'h0000_0040);
        check("br_valid", {31'd0, valid_d}, 32'd0);
        check("br_instr", instr_d, NOP);
        stall = 1'b0; pc_src = 2'd0;
        step();
        check("br_next_pc_d",  pc_d, 32'h0000_0040);
        check("br_next_instr", instr_d, 32'hCAFE_0040);
        check("br_next_valid", {31'd0, valid_d}, 32'd1);
        check("br_next_addr",  instr_addr, 32'h0000_0044);

        // JALR clears bit 0: 0x11 -> 0x10, aligned.
        pc_src = 2'd2; target = 32'h0000_0011;
        step();
        check("jalr_addr",  instr_addr, 32'h0000_0010);
        check("jalr_valid", {31'd0, valid_d}, 32'd0);

        // Halt request at PC=0x10.
        pc_src = 2'd0; halt_req = 1'b1;
        step();
        check("halt_halted",   {31'd0, halted}, 32'd1);
        check("halt_addr",     instr_addr, 32'h0000_0010);
        check("halt_valid",    {31'd0, valid_d}, 32'd0);
        check("halt_misalign", {31'd0, misalign}, 32'd0);
        halt_req = 1'b0; pc_src = 2'd1; target = 32'h0000_0080;
        step();
        check("halt_hold_addr",   instr_addr, 32'h0000_0010);
        check("halt_hold_halted", {31'd0, halted}, 32'd1);
        check("halt_hold_valid",  {31'd0, valid_d}, 32'd0);

        // Asynchronous reset mid-cycle, no clock edge before checking.
        #3 rst = 1'b1;
        #1 check_reset_state("async");
        step();
        rst = 1'b0; pc_src = 2'd3; target = 32'h0000_0080;
        step();
        check("reboot_addr", instr_addr, 32'h0000_0000);
        step();
        check("rsvd_seq_addr",  instr_addr, 32'h0000_0004);
        check("rsvd_seq_valid", {31'd0, valid_d}, 32'd1);

        // JALR to 0x23 -> 0x22 is misaligned: halt with PC unchanged.
        pc_src = 2'd2; target = 32'h0000_0023;
        step();
        check("mis_flag",   {31'd0, misalign}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_addr",   instr_addr, 32'h0000_0004);
        check("mis_valid",  {31'd0, valid_d}, 32'd0);
        check("mis_instr",  instr_d, NOP);
        pc_src = 2'd1; target = 32'h0000_0040;
        step();
        check("mis_hold_addr",  instr_addr, 32'h0000_0004);
        check("mis_hold_valid", {31'd0, valid_d}, 32'd0);
        check("mis_hold_flag",  {31'd0, misalign}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
